// File: rtl/baby_mem_xfer_ctrl.sv
// Sequences one Baby 32-bit memory request into a header byte plus four
// LSB-first data bytes on the 8-bit host port, paced by host strobe edges.
module baby_mem_xfer_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        baby_req_i,
   input  logic        baby_rw_i,
   input  logic [4:0]  baby_addr_i,
   input  logic [31:0] baby_data_i,
   output logic [31:0] baby_data_o,
   output logic        baby_ack_o,
   output logic        baby_stall_o,
   input  logic [7:0]  host_byte_i,
   input  logic        host_strobe_i,
   output logic [7:0]  host_byte_o,
   output logic        host_valid_o,
   output logic        host_dir_o,
   output logic        err_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_W0, S_W1, S_W2, S_W3, S_R0, S_R1, S_R2, S_R3, S_DONE
   } state_t;

   // Abort fires on the cycle the counter would reach all-ones.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t                 state, state_nx;
   logic                   rw_q;
   logic [4:0]             addr_q;
   logic [31:0]            wdata_q, rdata_q, data_q;
   logic                   err_q;
   logic [TIMEOUT_W-1:0]   wd_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   strb_prev_q;
   logic                   strb_edge, active, wd_expire;

   assign strb_edge = sync_q[SYNC_STAGES-1] & ~strb_prev_q;
   assign active    = (state != S_IDLE) && (state != S_DONE);
   assign wd_expire = active && !strb_edge && (wd_q == WD_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (baby_req_i) state_nx = S_HDR;
         S_HDR:  if (strb_edge)  state_nx = rw_q ? S_W0 : S_R0;
         S_W0:   if (strb_edge)  state_nx = S_W1;
         S_W1:   if (strb_edge)  state_nx = S_W2;
         S_W2:   if (strb_edge)  state_nx = S_W3;
         S_W3:   if (strb_edge)  state_nx = S_DONE;
         S_R0:   if (strb_edge)  state_nx = S_R1;
         S_R1:   if (strb_edge)  state_nx = S_R2;
         S_R2:   if (strb_edge)  state_nx = S_R3;
         S_R3:   if (strb_edge)  state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (wd_expire) state_nx = S_DONE;
   end

   // Host-side byte is a pure decode of state and latched request.
   always_comb begin
      host_byte_o = 8'h00;
      host_dir_o  = 1'b1;
      case (state)
         S_HDR: host_byte_o = {rw_q, 2'b00, addr_q};
         S_W0:  host_byte_o = wdata_q[7:0];
         S_W1:  host_byte_o = wdata_q[15:8];
         S_W2:  host_byte_o = wdata_q[23:16];
         S_W3:  host_byte_o = wdata_q[31:24];
         S_R0, S_R1, S_R2, S_R3: host_dir_o = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         data_q      <= '0;
         err_q       <= 1'b0;
         wd_q        <= '0;
         sync_q      <= '0;
         strb_prev_q <= 1'b0;
      end else begin
         state       <= state_nx;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], host_strobe_i};
         strb_prev_q <= sync_q[SYNC_STAGES-1];
         wd_q        <= (state_nx != state || !active) ? '0 : wd_q + 1'b1;
         if (state == S_IDLE && baby_req_i) begin
            rw_q    <= baby_rw_i;
            addr_q  <= baby_addr_i;
            wdata_q <= baby_data_i;
         end
         if (strb_edge) begin
            case (state)
               S_R0: rdata_q[7:0]   <= host_byte_i;
               S_R1: rdata_q[15:8]  <= host_byte_i;
               S_R2: rdata_q[23:16] <= host_byte_i;
               default: ;
            endcase
         end
         // Final read byte goes straight into the result; writes and aborts return 0.
         if (state_nx == S_DONE && state != S_DONE)
            data_q <= (state == S_R3 && strb_edge) ? {host_byte_i, rdata_q[23:0]} : '0;
         if (wd_expire) err_q <= 1'b1;
      end
   end

   assign baby_data_o  = data_q;
   assign baby_ack_o   = (state == S_DONE);
   assign baby_stall_o = (state != S_IDLE);
   assign host_valid_o = active;
   assign err_o        = err_q;

endmodule
